// File: rtl/ps_hit_counter.sv
// rtl/ps_hit_counter.sv - two-digit BCD hit counter with sticky wrap flag and seven-segment outputs
module ps_hit_counter #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       en,
    input  logic       clr,
    input  logic       mode_edge,
    output logic [7:0] cnt_bcd,
    output logic       ovf,
    output logic [7:0] seg0,
    output logic [7:0] seg1
);

    localparam logic [7:0] SEG_MASK  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] SEG_BLANK = SEG_MASK;
    localparam logic [7:0] SEG_ZERO  = 8'h3F ^ SEG_MASK;
    localparam logic [7:0] SEG1_RST  = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;

    logic       hit_d_q, hit_d_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic [7:0] seg0_q, seg0_d;
    logic [7:0] seg1_q, seg1_d;
    logic       inc;

    // dp (bit 7) stays off; polarity applied by the final XOR
    function automatic logic [7:0] seg_enc(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h00;
        endcase
        return {1'b0, pat} ^ SEG_MASK;
    endfunction

    always_comb begin
        hit_d_d = hit;
        inc     = en & (mode_edge ? (hit & ~hit_d_q) : hit);
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clr) begin
            cnt_d = 8'h00;
            ovf_d = 1'b0;
        end else if (inc) begin
            if (cnt_q[3:0] == 4'd9) begin
                cnt_d[3:0] = 4'd0;
                if (cnt_q[7:4] == 4'd9) begin
                    cnt_d[7:4] = 4'd0;
                    ovf_d      = 1'b1;
                end else begin
                    cnt_d[7:4] = cnt_q[7:4] + 4'd1;
                end
            end else begin
                cnt_d[3:0] = cnt_q[3:0] + 4'd1;
            end
        end
        seg0_d = seg_enc(cnt_q[3:0]);
        seg1_d = (BLANK_LEADING && (cnt_q[7:4] == 4'd0)) ? SEG_BLANK : seg_enc(cnt_q[7:4]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_d_q <= 1'b0;
            cnt_q   <= 8'h00;
            ovf_q   <= 1'b0;
            seg0_q  <= SEG_ZERO;
            seg1_q  <= SEG1_RST;
        end else begin
            hit_d_q <= hit_d_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            seg0_q  <= seg0_d;
            seg1_q  <= seg1_d;
        end
    end

    assign cnt_bcd = cnt_q;
    assign ovf     = ovf_q;
    assign seg0    = seg0_q;
    assign seg1    = seg1_q;

endmodule

// File: tb/tb_ps_hit_counter.sv
// tb/tb_ps_hit_counter.sv - randomized and directed bench for ps_hit_counter against an integer-count model
module tb_ps_hit_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hit, en, clr, mode_edge;
    logic [7:0] cnt_a, seg0_a, seg1_a;
    logic [7:0] cnt_b, seg0_b, seg1_b;
    logic       ovf_a, ovf_b;

    int n_vec = 0;
    int n_err = 0;

    int         m_cnt;
    bit         m_ovf, m_hd;
    logic [7:0] m_seg0a, m_seg1a, m_seg0b, m_seg1b;

    ps_hit_counter u_dut (
        .clk(clk), .reset(rst_n), .hit(hit), .en(en), .clr(clr), .mode_edge(mode_edge),
        .cnt_bcd(cnt_a), .ovf(ovf_a), .seg0(seg0_a), .seg1(seg1_a)
    );

    ps_hit_counter #(.SEG_ACTIVE_LOW(1'b0), .BLANK_LEADING(1'b0)) u_dut_ah (
        .clk(clk), .reset(rst_n), .hit(hit), .en(en), .clr(clr), .mode_edge(mode_edge),
        .cnt_bcd(cnt_b), .ovf(ovf_b), .seg0(seg0_b), .seg1(seg1_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_of(input int digit, input bit is_tens, input bit act_low, input bit blank_lead);
        logic [7:0] table_hi [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
        logic [7:0] v;
        v = (is_tens && blank_lead && digit == 0) ? 8'h00 : table_hi[digit];
        return act_low ? ~v : v;
    endfunction

    function automatic logic [7:0] bcd_of(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_ovf = 0; m_hd = 0;
        m_seg0a = seg_of(0, 0, 1, 1); m_seg1a = seg_of(0, 1, 1, 1);
        m_seg0b = seg_of(0, 0, 0, 0); m_seg1b = seg_of(0, 1, 0, 0);
    endtask

    task automatic model_edge(input bit h, input bit e, input bit c, input bit m);
        bit do_inc;
        m_seg0a = seg_of(m_cnt % 10, 0, 1, 1); m_seg1a = seg_of(m_cnt / 10, 1, 1, 1);
        m_seg0b = seg_of(m_cnt % 10, 0, 0, 0); m_seg1b = seg_of(m_cnt / 10, 1, 0, 0);
        do_inc = e && (m ? (h && !m_hd) : h);
        if (c) begin
            m_cnt = 0; m_ovf = 0;
        end else if (do_inc) begin
            if (m_cnt == 99) begin m_cnt = 0; m_ovf = 1; end
            else m_cnt = m_cnt + 1;
        end
        m_hd = h;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cnt"},  cnt_a,  bcd_of(m_cnt));
        check({tag, ".ovf"},  {7'd0, ovf_a}, {7'd0, m_ovf});
        check({tag, ".seg0"}, seg0_a, m_seg0a);
        check({tag, ".seg1"}, seg1_a, m_seg1a);
        check({tag, ".cntB"}, cnt_b,  bcd_of(m_cnt));
        check({tag, ".seg0B"}, seg0_b, m_seg0b);
        check({tag, ".seg1B"}, seg1_b, m_seg1b);
    endtask

    task automatic step(input string tag, input bit h, input bit e, input bit c, input bit m);
        hit = h; en = e; clr = c; mode_edge = m;
        @(posedge clk);
        model_edge(h, e, c, m);
        @(negedge clk);
        check_all(tag);
    endtask

    // asserted between edges; outputs must clear without a clock edge
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".cnt"},  cnt_a,  8'h00);
        check({tag, ".ovf"},  {7'd0, ovf_a}, 8'h00);
        check({tag, ".seg0"}, seg0_a, 8'hC0);
        check({tag, ".seg1"}, seg1_a, 8'hFF);
        check({tag, ".seg0B"}, seg0_b, 8'h3F);
        check({tag, ".seg1B"}, seg1_b, 8'h3F);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; hit = 0; en = 0; clr = 0; mode_edge = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst");
        rst_n = 1'b1;

        // level mode: five hits -> 05, seg0 shows '5' a cycle later
        for (int i = 0; i < 5; i++) step("lvl", 1, 1, 0, 0);
        check("lvl5", cnt_a, 8'h05);
        step("lvl_hold", 0, 0, 0, 0);
        check("lvl_seg0", seg0_a, 8'h92);

        // reset mid-count
        async_reset("rst_mid");

        // edge mode 1,1,1,0,1,1 -> 02
        step("e_clr", 0, 1, 1, 1);
        step("e", 1, 1, 0, 1); step("e", 1, 1, 0, 1); step("e", 1, 1, 0, 1);
        step("e", 0, 1, 0, 1); step("e", 1, 1, 0, 1); step("e", 1, 1, 0, 1);
        check("edge2", cnt_a, 8'h02);
        // same pattern with en=0 across the second rise -> 01
        step("e_clr", 0, 1, 1, 1);
        step("e", 1, 1, 0, 1); step("e", 1, 1, 0, 1); step("e", 1, 1, 0, 1);
        step("e", 0, 1, 0, 1); step("e", 1, 0, 0, 1); step("e", 1, 1, 0, 1);
        check("edge_en0", cnt_a, 8'h01);

        // carry 09 -> 10, then wrap 99 -> 00 with sticky ovf
        step("c_clr", 0, 1, 1, 0);
        for (int i = 0; i < 9; i++) step("carry", 1, 1, 0, 0);
        check("c09", cnt_a, 8'h09);
        step("carry", 1, 1, 0, 0);
        check("c10", cnt_a, 8'h10);
        step("carry", 0, 1, 0, 0);
        check("c10_seg1", seg1_a, 8'hF9);
        for (int i = 0; i < 89; i++) step("wrap", 1, 1, 0, 0);
        check("w99", cnt_a, 8'h99);
        step("wrap", 1, 1, 0, 0);
        check("w00", cnt_a, 8'h00);
        check("w_ovf", {7'd0, ovf_a}, 8'h01);
        for (int i = 0; i < 3; i++) step("wrap_more", 1, 1, 0, 0);
        check("w_ovf_sticky", {7'd0, ovf_a}, 8'h01);

        // clr beats inc on the same edge
        step("prio", 1, 1, 1, 0);
        check("prio_cnt", cnt_a, 8'h00);
        check("prio_ovf", {7'd0, ovf_a}, 8'h00);

        // randomized traffic with occasional long level runs and resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 3) async_reset("rnd_rst");
            else if (r < 8) begin
                for (int k = 0; k < 120; k++) step("rnd_run", 1, 1, 0, 0);
            end else
                step("rnd", 1'($urandom), $urandom_range(0, 9) != 0,
                     $urandom_range(0, 199) == 0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
